// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-flop synchroniser, debounce and single-cycle press pulse.
// Define AUTO_REPEAT_EN to add hold-to-auto-repeat (FSM states: IDLE wait | HOLD first delay | REPEAT periodic).
module button_conditioner #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] button_in,
  output logic [N_BUTTONS-1:0] button_level,
  output logic [N_BUTTONS-1:0] button_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [N_BUTTONS-1:0] sync1_q, sync2_q;
  logic [N_BUTTONS-1:0] level_q, level_d;
  logic [N_BUTTONS-1:0] pulse_q, pulse_d;
  logic [N_BUTTONS-1:0] rise;
  logic [CNT_W-1:0]     deb_cnt_q [N_BUTTONS];
  logic [CNT_W-1:0]     deb_cnt_d [N_BUTTONS];

  // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      deb_cnt_d[i] = '0;
      level_d[i]   = level_q[i];
      rise[i]      = 1'b0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
          rise[i]    = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rpt_state_e       state_q [N_BUTTONS];
  rpt_state_e       state_d [N_BUTTONS];
  logic [CNT_W-1:0] timer_q [N_BUTTONS];
  logic [CNT_W-1:0] timer_d [N_BUTTONS];

  // Release is judged on the next level so it suppresses a repeat due on the same edge.
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      pulse_d[i] = 1'b0;
      if (!level_d[i]) begin
        state_d[i] = ST_IDLE;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              pulse_d[i] = 1'b1;
              timer_d[i] = '0;
              state_d[i] = ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (timer_q[i] == DELAY_LAST) begin
              pulse_d[i] = 1'b1;
              timer_d[i] = '0;
              state_d[i] = ST_REPEAT;
            end else begin
              timer_d[i] = timer_q[i] + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (timer_q[i] == PERIOD_LAST) begin
              pulse_d[i] = 1'b1;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end
`else
  always_comb begin
    pulse_d = rise;
  end
`endif

  assign button_level = level_q;
  assign button_pulse = pulse_q;

endmodule
